// File: rtl/cpu6502_pkg.sv
// ---------------------------------------------------------------------------
// cpu6502_pkg
// Shared definitions for the 6502-style core:
//   flag_op_t  - flag instruction selector (FOP_*), 3 bits
//   br_cond_t  - branch condition, equal to opcode bits 7:5 of Bxx
//   P_*        - bit positions within the processor status byte
//   pflags_t   - the six flags that P actually stores (B and bit 5 are not state)
//   pack_p     - builds the byte pushed to the stack
//   branch_eval- branch decision from the stored flags
// ---------------------------------------------------------------------------
package cpu6502_pkg;

  typedef enum logic [2:0] {
    FOP_NONE = 3'd0,
    FOP_CLC  = 3'd1,
    FOP_SEC  = 3'd2,
    FOP_CLI  = 3'd3,
    FOP_SEI  = 3'd4,
    FOP_CLD  = 3'd5,
    FOP_SED  = 3'd6,
    FOP_CLV  = 3'd7
  } flag_op_t;

  typedef enum logic [2:0] {
    BR_BPL = 3'd0,
    BR_BMI = 3'd1,
    BR_BVC = 3'd2,
    BR_BVS = 3'd3,
    BR_BCC = 3'd4,
    BR_BCS = 3'd5,
    BR_BNE = 3'd6,
    BR_BEQ = 3'd7
  } br_cond_t;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } pflags_t;

  // Stack image of P: bit 5 reads as 1, bit 4 tells BRK/PHP apart from IRQ/NMI.
  function automatic logic [7:0] pack_p(input pflags_t f, input logic b);
    logic [7:0] r;
    r        = 8'h00;
    r[P_N]   = f.n;
    r[P_V]   = f.v;
    r[P_U]   = 1'b1;
    r[P_B]   = b;
    r[P_D]   = f.d;
    r[P_I]   = f.i;
    r[P_Z]   = f.z;
    r[P_C]   = f.c;
    return r;
  endfunction

  // cond[2:1] selects the flag (N,V,C,Z); cond[0] is the value that takes the branch.
  function automatic logic branch_eval(input pflags_t f, input logic [2:0] cond);
    logic flag;
    flag = 1'b0;
    case (cond[2:1])
      2'd0:    flag = f.n;
      2'd1:    flag = f.v;
      2'd2:    flag = f.c;
      default: flag = f.z;
    endcase
    return (flag == cond[0]);
  endfunction

endpackage

// File: rtl/cpu_status_reg_int_sync.sv
// ---------------------------------------------------------------------------
// int_sync
// Synchronizer for one asynchronous active-low interrupt line, followed by an
// optional falling-edge detector.
// Parameters:
//   DEPTH    number of synchronizer flops (2..3)
//   FALL_DET 0: active = synchronized level is low
//            1: active = one-cycle pulse on a synchronized 1->0 transition
// Ports:
//   clk     in  core clock
//   rst_n   in  asynchronous active-low reset; all flops reset to 1 (idle line)
//   line_n  in  raw asynchronous interrupt line, active-low
//   active  out level or edge indication, see FALL_DET
// ---------------------------------------------------------------------------
module int_sync #(
  parameter int DEPTH    = 2,
  parameter bit FALL_DET = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_n,
  output logic active
);

  // chain_reg[0] is the metastability-catching flop; the last bit is safe to use.
  logic [DEPTH-1:0] chain_reg;
  // Previous synchronized value, only needed for edge detection.
  logic             last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_reg <= '1;
      last_reg  <= 1'b1;
    end else begin
      chain_reg <= {chain_reg[DEPTH-2:0], line_n};
      last_reg  <= chain_reg[DEPTH-1];
    end
  end

  assign active = FALL_DET ? (last_reg & ~chain_reg[DEPTH-1])
                           : ~chain_reg[DEPTH-1];

endmodule

// File: rtl/cpu_status_reg.sv
// ---------------------------------------------------------------------------
// cpu_status_reg
// Processor status register P of a 6502-style core, plus branch evaluation and
// interrupt qualification at instruction boundaries.
//
// Optional feature macro: CPU_DECIMAL_EN
//   defined   : d_mode follows the stored D flag
//   undefined : D is still stored/loaded/pushed, but d_mode is tied to 0
//
// Parameters:
//   RESET_I   value of I after reset
//   NMI_SYNC  synchronizer depth on irq_n / nmi_n (2..3)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   alu_n/v/z/c                flags from the ALU
//   upd_nz, upd_v, upd_c       per-flag load enables from the ALU
//   flag_op[2:0]               CLC/SEC/CLI/SEI/CLD/SED/CLV (flag_op_t)
//   load_p, db_in[7:0]         PLP/RTI load of P (bits 5,4 ignored)
//   brk_push                   B bit placed into p_push
//   p_push[7:0]                stack image {N,V,1,B,D,I,Z,C}
//   ci                         current C for ALU carry-in
//   d_mode                     decimal mode to the ALU
//   br_cond[2:0], br_taken     branch condition in, combinational decision out
//   irq_n, nmi_n               asynchronous interrupt lines, active-low
//   sync                       opcode fetch cycle (instruction boundary)
//   int_ack                    interrupt sequence committed
//   sei_on_int                 set I during the vector fetch
//   nmi_take, irq_take         registered interrupt decisions, updated on sync
// ---------------------------------------------------------------------------
module cpu_status_reg
  import cpu6502_pkg::*;
#(
  parameter logic RESET_I  = 1'b1,
  parameter int   NMI_SYNC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       upd_nz,
  input  logic       upd_v,
  input  logic       upd_c,
  input  logic [2:0] flag_op,
  input  logic       load_p,
  input  logic [7:0] db_in,
  input  logic       brk_push,
  output logic [7:0] p_push,
  output logic       ci,
  output logic       d_mode,
  input  logic [2:0] br_cond,
  output logic       br_taken,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       sync,
  input  logic       int_ack,
  input  logic       sei_on_int,
  output logic       nmi_take,
  output logic       irq_take
);

  localparam pflags_t P_RESET = '{n: 1'b0, v: 1'b0, d: 1'b0, i: RESET_I, z: 1'b0, c: 1'b0};

  // -------------------------------------------------------------------------
  // Status flags
  // -------------------------------------------------------------------------
  pflags_t  p_reg;
  pflags_t  p_next;
  flag_op_t fop;

  assign fop = flag_op_t'(flag_op);

  // B and bit 5 are not stored, so those bus bits are deliberately dropped.
  logic db_unused;
  assign db_unused = db_in[P_U] ^ db_in[P_B];

  always_comb begin
    p_next = p_reg;
    if (load_p) begin
      p_next.n = db_in[P_N];
      p_next.v = db_in[P_V];
      p_next.d = db_in[P_D];
      p_next.i = db_in[P_I];
      p_next.z = db_in[P_Z];
      p_next.c = db_in[P_C];
    end else begin
      // Lowest priority first; later assignments override earlier ones.
      if (sei_on_int) p_next.i = 1'b1;
      if (upd_nz) begin
        p_next.n = alu_n;
        p_next.z = alu_z;
      end
      if (upd_v) p_next.v = alu_v;
      if (upd_c) p_next.c = alu_c;
      // A flag instruction only overrides its own bit.
      case (fop)
        FOP_CLC: p_next.c = 1'b0;
        FOP_SEC: p_next.c = 1'b1;
        FOP_CLI: p_next.i = 1'b0;
        FOP_SEI: p_next.i = 1'b1;
        FOP_CLD: p_next.d = 1'b0;
        FOP_SED: p_next.d = 1'b1;
        FOP_CLV: p_next.v = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg <= P_RESET;
    end else begin
      p_reg <= p_next;
    end
  end

  assign p_push   = pack_p(p_reg, brk_push);
  assign ci       = p_reg.c;
  assign br_taken = branch_eval(p_reg, br_cond);

`ifdef CPU_DECIMAL_EN
  assign d_mode = p_reg.d;
`else
  // 2A03-style: D is architecturally visible but never reaches the ALU.
  assign d_mode = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Interrupt qualification
  // -------------------------------------------------------------------------
  logic irq_active;
  logic nmi_fall;

  int_sync #(.DEPTH(NMI_SYNC), .FALL_DET(1'b0)) u_irq_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_n (irq_n),
    .active (irq_active)
  );

  int_sync #(.DEPTH(NMI_SYNC), .FALL_DET(1'b1)) u_nmi_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_n (nmi_n),
    .active (nmi_fall)
  );

  logic nmi_latch_reg;
  logic nmi_latch_next;
  logic nmi_take_reg;
  logic irq_take_reg;
  // I as captured at the previous instruction boundary; masking IRQ with this
  // delays CLI/SEI/PLP by one instruction, as on the original part.
  logic i_eff_reg;

  // The latch is cleared once the NMI it announced is acknowledged; a fresh
  // edge arriving in the same cycle must not be lost, so set wins.
  always_comb begin
    nmi_latch_next = nmi_fall | (nmi_latch_reg & ~(int_ack & nmi_take_reg));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_latch_reg <= 1'b0;
      nmi_take_reg  <= 1'b0;
      irq_take_reg  <= 1'b0;
      i_eff_reg     <= RESET_I;
    end else begin
      nmi_latch_reg <= nmi_latch_next;
      if (sync) begin
        nmi_take_reg <= nmi_latch_reg;
        irq_take_reg <= ~nmi_latch_reg & irq_active & ~i_eff_reg;
        i_eff_reg    <= p_reg.i;
      end
    end
  end

  assign nmi_take = nmi_take_reg;
  assign irq_take = irq_take_reg;

endmodule
